alu_execute_stage: RTL
======================

// Module: alu_execute_stage
// PURPOSE
//  Registered ARM data-processing execute stage directly downstream of the barrel shifter.
//  Consumes Rn and the shifted operand2 plus shifter carry; evaluates the condition code,
//  computes the 16 DP opcodes, and owns the NZCV flag register. Its C flag drives shifter cf_in.
//  One result per cycle through a single output register with valid/ready backpressure.
// PARAMETERS
//  DATA_W      32       datapath width (only 32 is supported)
//  RESET_NZCV  4'b0000  NZCV value loaded on reset
// PORTS
//  clk           in   1       clock
//  rst           in   1       synchronous, active-high reset
//  in_valid      in   1       input operation valid
//  in_ready      out  1       stage can accept an operation this cycle
//  in_opcode     in   4       ARM DP opcode: AND=0, EOR, SUB, RSB, ADD, ADC, SBC, RSC, TST, TEQ, CMP, CMN, ORR, MOV, BIC, MVN=F
//  in_s          in   1       S bit: update flags
//  in_cond       in   4       ARM condition field (EQ=0 .. AL=E; NV=F treated as never)
//  in_rn         in   32      first operand
//  in_op2        in   32      shifted operand, from barrel shifter data_out
//  in_shift_cf   in   1       shifter carry, from barrel shifter cf_out
//  in_rd         in   4       destination register index
//  out_valid     out  1       result register holds an operation
//  out_ready     in   1       consumer accepts the result
//  out_result    out  32      ALU result
//  out_rd        out  4       destination index
//  out_wr_en     out  1       1 = write result to out_rd
//  flags_nzcv    out  4       current flags {N,Z,C,V}
//  flag_c        out  1       flags_nzcv[1]; wired to shifter cf_in
// BEHAVIOUR
//  - Reset: out_valid=0, out_result=0, out_rd=0, out_wr_en=0, flags_nzcv=RESET_NZCV.
//    Reset overrides any transfer in the same cycle; an in-flight result is dropped.
//  - in_ready = !out_valid | out_ready. Accept = in_valid & in_ready.
//  - On accept, the output register loads on the next edge (latency 1) and out_valid=1.
//    Output fields are held stable while out_valid & !out_ready.
//    out_valid clears when out_ready and no new accept occurs.
//  - cond_pass is evaluated against flags_nzcv as of the accept cycle.
//    A failed condition still produces an output (ordering kept) with out_wr_en=0.
//    Flags are unchanged on a failed condition.
//  - Arithmetic is 33-bit:
//      ADD/CMN = Rn+Op2
//      ADC     = Rn+Op2+C
//      SUB/CMP = Rn+~Op2+1
//      SBC     = Rn+~Op2+C
//      RSB     = Op2+~Rn+1
//      RSC     = Op2+~Rn+C
//    C = bit 32 of the sum (for subtracts, C = NOT borrow).
//    V = (a[31]==b'[31]) & (res[31]!=a[31]), where b' is the inverted operand for subtracts.
//  - Logical ops (AND EOR TST TEQ ORR MOV BIC MVN): C = in_shift_cf, V unchanged.
//  - N = res[31]; Z = (res==0).
//  - TST/TEQ/CMP/CMN: out_wr_en=0; flags update on cond_pass regardless of in_s.
//    Other ops update flags only when in_s=1, and set out_wr_en=cond_pass.
//  - Flag update takes effect on the accept edge, so a back-to-back next instruction
//    sees the new flags with no bubble.
//  - Wrap-around: results truncate to 32 bits.
//    0xFFFFFFFF+1 -> 0 with N=0, Z=1, C=1, V=0.
//    0x7FFFFFFF+1 -> 0x80000000 with N=1, V=1, C=0.
// CONFIGURATION
//  ALU_FLAG_LOAD_EN
//    Defined: adds ports flag_ld (in 1) and flag_ld_nzcv (in 4), for an MSR-style direct flag write.
//      flag_ld loads flags_nzcv on the next edge.
//      If an accept with a flag update occurs in the same cycle, flag_ld wins.
//      flag_ld is independent of the handshake.
//    Undefined: these ports are absent; flags change only via DP operations and reset.
// STRUCTURE
//  - alu_pkg: opcode localparams (OP_AND..OP_MVN), condition localparams (COND_EQ..COND_NV),
//    and NZCV bit-position constants.
//  - Sub-module arm_cond_check: combinational (cond, nzcv) -> pass.
//  - The rest is flat: adder, logic unit, flag logic, output register.
// TESTING
//  1. ADD, S=1, cond=AL, Rn=0xFFFFFFFF, Op2=1
//     -> next cycle out_result=0, out_wr_en=1, flags=4'b0110.
//  2. CMP, Rn=5, Op2=5, S=0
//     -> out_wr_en=0, flags=4'b0110 (Z=1, C=1); then MOVEQ Op2=0x12
//     -> out_result=0x12, out_wr_en=1.
//  3. MOVNE after flags Z=1
//     -> out_valid=1, out_wr_en=0, flags unchanged.
//  4. ANDS, Op2=0x80000000, Rn=0xFFFFFFFF, in_shift_cf=1, V=1 preset
//     -> flags=4'b1011.
//  5. Hold out_ready=0 for 3 cycles while in_valid=1
//     -> in_ready=0, output fields stable, flags stable; release
//     -> the next op is accepted the same cycle, no loss or duplication.
//  6. Assert rst mid-stream with out_valid=1
//     -> next cycle out_valid=0, flags=RESET_NZCV.
//     With ALU_FLAG_LOAD_EN: flag_ld=1, nzcv=4'b1001 together with ADDS
//     -> flags=4'b1001.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ARM data-processing opcodes, condition codes and NZCV bit positions
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

endpackage

// File: rtl/arm_cond_check.sv
// rtl/arm_cond_check.sv - combinational ARM condition-field evaluation against NZCV
module arm_cond_check
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[NZCV_N];
  assign z = nzcv[NZCV_Z];
  assign c = nzcv[NZCV_C];
  assign v = nzcv[NZCV_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_execute_stage.sv
// rtl/alu_execute_stage.sv - registered ARM DP execute stage with NZCV flag register
// Optional MSR-style flag write port enabled by ALU_FLAG_LOAD_EN.
module alu_execute_stage
  import alu_pkg::*;
#(
  parameter int         DATA_W     = 32,
  parameter logic [3:0] RESET_NZCV = 4'b0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic              in_s,
  input  logic [3:0]        in_cond,
  input  logic [DATA_W-1:0] in_rn,
  input  logic [DATA_W-1:0] in_op2,
  input  logic              in_shift_cf,
  input  logic [3:0]        in_rd,
`ifdef ALU_FLAG_LOAD_EN
  input  logic              flag_ld,
  input  logic [3:0]        flag_ld_nzcv,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [3:0]        out_rd,
  output logic              out_wr_en,
  output logic [3:0]        flags_nzcv,
  output logic              flag_c
);

  localparam int MSB = DATA_W - 1;

  logic              accept, cond_pass, is_arith, is_test, flag_upd;
  logic [DATA_W-1:0] add_a, add_b, logic_res, alu_res;
  logic              add_cin;
  logic [DATA_W:0]   sum;
  logic [3:0]        new_nzcv;

  arm_cond_check u_cond (
    .cond (in_cond),
    .nzcv (flags_nzcv),
    .pass (cond_pass)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign is_test  = (in_opcode[3:2] == 2'b10);
  assign flag_c   = flags_nzcv[NZCV_C];

  // Subtracts are folded into the adder as a + ~b + carry-in, so C is NOT borrow.
  always_comb begin
    add_a    = in_rn;
    add_b    = in_op2;
    add_cin  = 1'b0;
    is_arith = 1'b1;
    case (in_opcode)
      OP_ADD, OP_CMN: begin end
      OP_ADC: add_cin = flags_nzcv[NZCV_C];
      OP_SUB, OP_CMP: begin
        add_b   = ~in_op2;
        add_cin = 1'b1;
      end
      OP_SBC: begin
        add_b   = ~in_op2;
        add_cin = flags_nzcv[NZCV_C];
      end
      OP_RSB: begin
        add_a   = in_op2;
        add_b   = ~in_rn;
        add_cin = 1'b1;
      end
      OP_RSC: begin
        add_a   = in_op2;
        add_b   = ~in_rn;
        add_cin = flags_nzcv[NZCV_C];
      end
      default: is_arith = 1'b0;
    endcase
  end

  always_comb begin
    logic_res = ~in_op2;
    case (in_opcode)
      OP_AND, OP_TST: logic_res = in_rn & in_op2;
      OP_EOR, OP_TEQ: logic_res = in_rn ^ in_op2;
      OP_ORR:         logic_res = in_rn | in_op2;
      OP_MOV:         logic_res = in_op2;
      OP_BIC:         logic_res = in_rn & ~in_op2;
      default:        logic_res = ~in_op2;
    endcase
  end

  assign sum     = {1'b0, add_a} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_cin};
  assign alu_res = is_arith ? sum[MSB:0] : logic_res;

  always_comb begin
    new_nzcv         = flags_nzcv;
    new_nzcv[NZCV_N] = alu_res[MSB];
    new_nzcv[NZCV_Z] = (alu_res == '0);
    new_nzcv[NZCV_C] = is_arith ? sum[DATA_W] : in_shift_cf;
    if (is_arith)
      new_nzcv[NZCV_V] = (add_a[MSB] == add_b[MSB]) && (alu_res[MSB] != add_a[MSB]);
  end

  assign flag_upd = accept && cond_pass && (is_test || in_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
      out_wr_en  <= 1'b0;
      flags_nzcv <= RESET_NZCV;
    end else begin
      if (accept) begin
        out_valid  <= 1'b1;
        out_result <= alu_res;
        out_rd     <= in_rd;
        out_wr_en  <= cond_pass && !is_test;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
`ifdef ALU_FLAG_LOAD_EN
      if (flag_ld)
        flags_nzcv <= flag_ld_nzcv;
      else if (flag_upd)
        flags_nzcv <= new_nzcv;
`else
      if (flag_upd)
        flags_nzcv <= new_nzcv;
`endif
    end
  end

endmodule
